// File: rtl/fp_int_pkg.sv
// rtl/fp_int_pkg.sv - shared widths, scheduler state and job record for the fp16 x intN multiplier path
package fp_int_pkg;
  localparam int FP16_SIGN_W = 1;
  localparam int FP16_EXP_W  = 5;
  localparam int FP16_MAN_W  = 10;
  localparam int ACT_WIDTH   = FP16_SIGN_W + FP16_EXP_W + FP16_MAN_W;
  localparam int W_MAX       = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic [ACT_WIDTH-1:0] act;
    logic [W_MAX-1:0]     w;
  } job_t;
endpackage

// File: rtl/fp_int_mul_sched_fifo.sv
// rtl/fp_int_mul_sched_fifo.sv - synchronous job FIFO with registered full/empty
// Pointers carry one extra MSB so full and empty are distinguishable when the indices match.
module sched_job_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
  logic             do_push, do_pop;

  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign wr_ptr_nx = wr_ptr + (AW+1)'(do_push);
  assign rd_ptr_nx = rd_ptr + (AW+1)'(do_pop);
  assign dout      = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_nx;
      rd_ptr <= rd_ptr_nx;
      empty  <= (wr_ptr_nx == rd_ptr_nx);
      full   <= (wr_ptr_nx[AW-1:0] == rd_ptr_nx[AW-1:0]) && (wr_ptr_nx[AW] != rd_ptr_nx[AW]);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/fp_int_mul_sched.sv
// rtl/fp_int_mul_sched.sv - job scheduler streaming weights MSB-first into the bit-serial fp_int_mul
// Optional perf_active/perf_stall counters under FP_INT_MUL_SCHED_PERF_EN.
module fp_int_mul_sched #(
  parameter int ACT_WIDTH = fp_int_pkg::ACT_WIDTH,
  parameter int W_MAX     = fp_int_pkg::W_MAX,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ACT_WIDTH-1:0] in_act,
  input  logic [W_MAX-1:0]     in_w,
  input  logic                 cfg_we,
  input  logic [3:0]           cfg_prec,
  output logic                 cfg_err,
  output logic [ACT_WIDTH-1:0] mul_act,
  output logic                 mul_w,
  output logic                 mul_valid,
  output logic [3:0]           mul_precision,
  input  logic                 mul_start_acc,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] jobs_done
`ifdef FP_INT_MUL_SCHED_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] perf_active,
  output logic [CNT_WIDTH-1:0] perf_stall
`endif
);
  import fp_int_pkg::*;

  localparam int BW = $clog2(W_MAX);

  job_t             fifo_din, fifo_dout;
  logic             fifo_full, fifo_empty, fifo_pop, push, ready_en;
  logic             cfg_ok, cfg_idle;
  sched_state_e     state;
  logic [ACT_WIDTH-1:0] act_r;
  logic [W_MAX-1:0] w_r;
  logic [BW-1:0]    bit_idx, prec_m1;

  // ready_en keeps in_ready low until the first edge after reset release
  assign in_ready     = ready_en & ~fifo_full;
  assign push         = in_valid & in_ready;
  assign fifo_din.act = in_act;
  assign fifo_din.w   = in_w;
  assign fifo_pop     = ~fifo_empty && (state == IDLE || bit_idx == '0);
  assign prec_m1      = BW'(mul_precision - 4'd1);
  assign busy         = ~fifo_empty || (state == STREAM);
  assign cfg_ok       = (cfg_prec != 4'd0) && (int'(cfg_prec) <= W_MAX);
  assign cfg_idle     = (state == IDLE) && fifo_empty;

  sched_job_fifo #(.WIDTH($bits(job_t)), .DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (fifo_pop),
    .din  (fifo_din),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ready_en  <= 1'b0;
      act_r     <= '0;
      w_r       <= '0;
      bit_idx   <= '0;
      mul_valid <= 1'b0;
      mul_w     <= 1'b0;
      mul_act   <= '0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        IDLE: begin
          mul_valid <= 1'b0;
          mul_w     <= 1'b0;
          if (!fifo_empty) begin
            act_r   <= fifo_dout.act;
            w_r     <= fifo_dout.w;
            bit_idx <= prec_m1;
            state   <= STREAM;
          end
        end
        STREAM: begin
          mul_valid <= 1'b1;
          mul_act   <= act_r;
          mul_w     <= w_r[bit_idx];
          if (bit_idx == '0) begin
            // reload on the last bit so consecutive jobs stream without a gap
            if (!fifo_empty) begin
              act_r   <= fifo_dout.act;
              w_r     <= fifo_dout.w;
              bit_idx <= prec_m1;
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_idx <= bit_idx - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_precision <= 4'(W_MAX);
      cfg_err       <= 1'b0;
    end else if (cfg_we) begin
      if (cfg_ok && cfg_idle) mul_precision <= cfg_prec;
      else                    cfg_err       <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             jobs_done <= '0;
    else if (mul_start_acc && ~&jobs_done) jobs_done <= jobs_done + CNT_WIDTH'(1);
  end

`ifdef FP_INT_MUL_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_active <= '0;
      perf_stall  <= '0;
    end else begin
      if (mul_valid && ~&perf_active)             perf_active <= perf_active + CNT_WIDTH'(1);
      if (in_valid && !in_ready && ~&perf_stall)  perf_stall  <= perf_stall + CNT_WIDTH'(1);
    end
  end
`endif
endmodule

// File: tb/tb_fp_int_mul_sched.sv
// tb/tb_fp_int_mul_sched.sv - directed vector bench for fp_int_mul_sched
module tb_fp_int_mul_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] in_act;
  logic [7:0]  in_w;
  logic        cfg_we, cfg_err;
  logic [3:0]  cfg_prec, mul_precision;
  logic [15:0] mul_act;
  logic        mul_w, mul_valid, mul_start_acc, busy;
  logic [15:0] jobs_done;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0]  prec;
    logic [15:0] act;
    logic [7:0]  w;
    logic [7:0]  exp_seq;
  } vec_t;

  vec_t vecs [6];
  bit   b2b_v [10] = '{0, 0, 1, 1, 1, 1, 1, 1, 0, 0};
  bit   b2b_e [10] = '{0, 0, 1, 0, 0, 1, 1, 1, 0, 0};
  logic [7:0] b2b_w [3] = '{8'h02, 8'h01, 8'h03};
  logic [7:0] fw [6] = '{8'h81, 8'h5A, 8'hC3, 8'h3C, 8'hE7, 8'h18};
  int   acc_edge [6];

  always #5 clk = ~clk;

  fp_int_mul_sched dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_act       (in_act),
    .in_w         (in_w),
    .cfg_we       (cfg_we),
    .cfg_prec     (cfg_prec),
    .cfg_err      (cfg_err),
    .mul_act      (mul_act),
    .mul_w        (mul_w),
    .mul_valid    (mul_valid),
    .mul_precision(mul_precision),
    .mul_start_acc(mul_start_acc),
    .busy         (busy),
    .jobs_done    (jobs_done)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    cfg_we = 1'b0;
    mul_start_acc = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
  endtask

  task automatic set_prec(input logic [3:0] p);
    cfg_prec = p;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic push_job(input logic [15:0] act, input logic [7:0] w);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("push_ready", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_act = act;
    in_w = w;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int   nxt, nbits, stale;
    logic acc;

    vecs[0] = '{4'd4, 16'h3C00, 8'h0B, 8'hB0};
    vecs[1] = '{4'd3, 16'hC500, 8'hF5, 8'hA0};
    vecs[2] = '{4'd8, 16'h7BFF, 8'hA5, 8'hA5};
    vecs[3] = '{4'd1, 16'h0001, 8'hFE, 8'h00};
    vecs[4] = '{4'd1, 16'h3800, 8'h01, 8'h80};
    vecs[5] = '{4'd2, 16'hBC00, 8'h06, 8'h80};

    rst = 1'b1;
    in_valid = 1'b0;
    in_act = '0;
    in_w = '0;
    cfg_we = 1'b0;
    cfg_prec = '0;
    mul_start_acc = 1'b0;
    #3;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_mul_valid", {31'b0, mul_valid}, 32'd0);
    chk("rst_mul_w", {31'b0, mul_w}, 32'd0);
    chk("rst_mul_act", {16'b0, mul_act}, 32'd0);
    chk("rst_prec", {28'b0, mul_precision}, 32'd8);
    chk("rst_cfg_err", {31'b0, cfg_err}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_jobs_done", {16'b0, jobs_done}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    mul_start_acc = 1'b1;
    repeat (3) tick();
    mul_start_acc = 1'b0;
    chk("jobs_done_3", {16'b0, jobs_done}, 32'd3);

    for (int i = 0; i < 6; i++) begin
      set_prec(vecs[i].prec);
      chk("prec_upd", {28'b0, mul_precision}, {28'b0, vecs[i].prec});
      push_job(vecs[i].act, vecs[i].w);
      tick();
      chk("lat_gap", {31'b0, mul_valid}, 32'd0);
      for (int k = 0; k < int'(vecs[i].prec); k++) begin
        tick();
        chk("vec_valid", {31'b0, mul_valid}, 32'd1);
        chk("vec_w", {31'b0, mul_w}, {31'b0, vecs[i].exp_seq[7-k]});
        chk("vec_act", {16'b0, mul_act}, {16'b0, vecs[i].act});
      end
      tick();
      chk("vec_end_valid", {31'b0, mul_valid}, 32'd0);
      chk("vec_end_busy", {31'b0, busy}, 32'd0);
    end
    chk("table_cfg_err", {31'b0, cfg_err}, 32'd0);

    set_prec(4'd2);
    chk("b2b_prec", {28'b0, mul_precision}, 32'd2);
    for (int c = 0; c < 10; c++) begin
      if (c < 3) begin
        in_valid = 1'b1;
        in_w = b2b_w[c];
        in_act = 16'h4400 + 16'(c);
        chk("b2b_ready", {31'b0, in_ready}, 32'd1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      chk("b2b_valid", {31'b0, mul_valid}, {31'b0, b2b_v[c]});
      if (b2b_v[c]) chk("b2b_w", {31'b0, mul_w}, {31'b0, b2b_e[c]});
    end

    set_prec(4'd8);
    nxt = 0;
    nbits = 0;
    for (int c = 0; c < 60; c++) begin
      if (nxt < 6) begin
        in_valid = 1'b1;
        in_act = 16'h5000 + 16'(nxt);
        in_w = fw[nxt];
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        acc_edge[nxt] = c;
        nxt++;
      end
      if (c == 4) chk("full_ready_low", {31'b0, in_ready}, 32'd0);
      if (mul_valid) begin
        if (nbits < 48) begin
          chk("full_w", {31'b0, mul_w}, {31'b0, fw[nbits/8][7 - (nbits % 8)]});
          chk("full_act", {16'b0, mul_act}, 32'h5000 + 32'(nbits / 8));
        end
        nbits++;
      end
    end
    in_valid = 1'b0;
    chk("full_bits", nbits, 48);
    chk("full_accept5", acc_edge[4], 4);
    chk("full_accept6", acc_edge[5], 10);
    chk("full_end_busy", {31'b0, busy}, 32'd0);

    push_job(16'h3C00, 8'hFF);
    cfg_prec = 4'd3;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    chk("cfg_busy_prec", {28'b0, mul_precision}, 32'd8);
    chk("cfg_busy_err", {31'b0, cfg_err}, 32'd1);
    repeat (12) tick();
    chk("cfg_busy_drain", {31'b0, busy}, 32'd0);
    chk("cfg_err_sticky", {31'b0, cfg_err}, 32'd1);

    do_reset();
    chk("cfg_err_cleared", {31'b0, cfg_err}, 32'd0);
    set_prec(4'd0);
    chk("cfg_zero_prec", {28'b0, mul_precision}, 32'd8);
    chk("cfg_zero_err", {31'b0, cfg_err}, 32'd1);
    do_reset();
    set_prec(4'd9);
    chk("cfg_nine_prec", {28'b0, mul_precision}, 32'd8);
    chk("cfg_nine_err", {31'b0, cfg_err}, 32'd1);
    do_reset();
    set_prec(4'd3);
    chk("cfg_three_prec", {28'b0, mul_precision}, 32'd3);
    chk("cfg_three_err", {31'b0, cfg_err}, 32'd0);

    set_prec(4'd8);
    mul_start_acc = 1'b1;
    repeat (2) tick();
    mul_start_acc = 1'b0;
    chk("mid_jobs_done", {16'b0, jobs_done}, 32'd2);
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_act = 16'h6000 + 16'(c);
      in_w = 8'hFF;
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("mid_streaming", {31'b0, mul_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, mul_valid}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_jobs", {16'b0, jobs_done}, 32'd0);
    chk("mid_rst_ready", {31'b0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    stale = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (mul_valid) stale++;
    end
    chk("mid_no_stale", stale, 0);
    chk("mid_idle_busy", {31'b0, busy}, 32'd0);

    mul_start_acc = 1'b1;
    repeat (65534) tick();
    chk("sat_fffe", {16'b0, jobs_done}, 32'hFFFE);
    repeat (5) tick();
    chk("sat_ffff", {16'b0, jobs_done}, 32'hFFFF);
    mul_start_acc = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
